// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the data-memory access path: size encodings,
// sequencer states, byte-strobe masks and the natural-alignment rule.
`timescale 1ns/1ps
package mem_ctrl_pkg;

  localparam int width = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SZ_B:    return 1'b1;
      SZ_H:    return ~off[0];
      SZ_W:    return off[1:0] == 2'b00;
      default: return off == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response bundle and data-memory port bundle.
// Master is the initiator of each bundle (memory stage, resp. the controller).
`timescale 1ns/1ps
interface mem_req_if #(parameter int DATA_W = mem_ctrl_pkg::width);
  logic              req_valid;
  logic              req_write;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic              stall;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              misaligned;
  logic              bus_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    input  stall, resp_valid, resp_rdata, misaligned, bus_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    output stall, resp_valid, resp_rdata, misaligned, bus_err
  );
endinterface

interface dm_if #(parameter int DATA_W = mem_ctrl_pkg::width);
  logic                  dm_req;
  logic                  dm_we;
  logic [DATA_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W/8-1:0]   dm_wstrb;
  logic                  dm_ready;
  logic [DATA_W-1:0]     dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    input  dm_ready, dm_rdata
  );
  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    output dm_ready, dm_rdata
  );
endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational byte-lane alignment: store shift + strobes, load shift + sign/zero
// extension. Zero latency, no handshake; reusable by write-back.
`timescale 1ns/1ps
module mem_lane_align
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = width
) (
  input  logic [1:0]        size,
  input  logic [2:0]        off,
  input  logic              zext,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] st_lane,
  output logic [7:0]        st_strb,
  input  logic [DATA_W-1:0] ld_lane,
  output logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] ld_sh;

  assign st_lane = st_data << {off, 3'b000};
  assign st_strb = size_mask(size) << off;
  assign ld_sh   = ld_lane >> {off, 3'b000};

  always_comb begin
    ld_data = ld_sh;
    case (size)
      SZ_B:    ld_data = {{(DATA_W-8){~zext & ld_sh[7]}},   ld_sh[7:0]};
      SZ_H:    ld_data = {{(DATA_W-16){~zext & ld_sh[15]}}, ld_sh[15:0]};
      SZ_W:    ld_data = {{(DATA_W-32){~zext & ld_sh[31]}}, ld_sh[31:0]};
      default: ld_data = ld_sh;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: IDLE -> BUSY (dm_req held until dm_ready or timeout) -> RESP.
// Latency 3 cycles with a zero-wait memory, +1 per wait cycle; stalls the pipeline until RESP.
`timescale 1ns/1ps
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W  = width,
  parameter int TIMEOUT = 256
) (
  input  logic      sys_clk,
  input  logic      sys_rst,
  mem_req_if.slave  req,
  dm_if.master      dm
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic              accept, reject, done, tout;
  logic              wr_q, zext_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              misal_q, berr_q;
  logic              busy, in_resp;
  logic [DATA_W-1:0] st_lane, ld_data;
  logic [7:0]        st_strb;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size    (size_q),
    .off     (addr_q[2:0]),
    .zext    (zext_q),
    .st_data (wdata_q),
    .st_lane (st_lane),
    .st_strb (st_strb),
    .ld_lane (dm.dm_rdata),
    .ld_data (ld_data)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    done    = 1'b0;
    tout    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          if (is_aligned(req.req_size, req.req_addr[2:0])) begin
            accept  = 1'b1;
            state_d = BUSY;
          end else begin
            reject  = 1'b1;
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        // A ready on the last allowed cycle wins over the timeout.
        if (dm.dm_ready) begin
          done    = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tout    = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_q    <= 1'b0;
      zext_q  <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      misal_q <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= req.req_write;
        zext_q  <= req.req_unsigned;
        size_q  <= req.req_size;
        addr_q  <= req.req_addr;
        wdata_q <= req.req_wdata;
        rdata_q <= '0;
        cnt_q   <= '0;
        misal_q <= 1'b0;
        berr_q  <= 1'b0;
      end
      if (reject) begin
        rdata_q <= '0;
        misal_q <= 1'b1;
        berr_q  <= 1'b0;
      end
      if (busy && !done && !tout) cnt_q <= cnt_q + 1'b1;
      if (done) rdata_q <= wr_q ? '0 : ld_data;
      if (tout) begin
        rdata_q <= '0;
        berr_q  <= 1'b1;
      end
    end
  end

  assign busy    = (state_q == BUSY);
  assign in_resp = (state_q == RESP);

  // Gated by reset so the pipeline unfreezes the instant reset asserts.
  assign req.stall      = ~sys_rst & (((state_q == IDLE) & req.req_valid) | busy);
  assign req.resp_valid = in_resp;
  assign req.resp_rdata = in_resp ? rdata_q : '0;
  assign req.misaligned = in_resp & misal_q;
  assign req.bus_err    = in_resp & berr_q;

  assign dm.dm_req   = busy;
  assign dm.dm_we    = busy & wr_q;
  assign dm.dm_addr  = {addr_q[DATA_W-1:3], 3'b000};
  assign dm.dm_wdata = st_lane;
  assign dm.dm_wstrb = (busy & wr_q) ? st_strb : 8'h00;

endmodule
